execute_mc: RTL and testbench

Parametrised Y86 execute stage that replaces the purely combinational execute.
- Registers the condition codes on the clock, with set-CC gated by downstream exceptions.
- Adds a multi-cycle iterative OPq multiply (ifun 4) with a stall handshake to the pipeline control.
- Sits between the E and M pipeline registers and drives the e_* bus into memory and forwarding.

---
 rtl/y86_pkg.sv | 67 ++++++
 rtl/execute_mc_if.sv | 37 +++
 rtl/seq_multiplier.sv | 99 +++++++++
 rtl/execute_mc.sv | 149 ++++++++++++++
 tb/tb_execute_mc.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the execute stage: icodes, ALU functions, status codes,
// register ids, condition codes and the multiply FSM state type.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] ALUADD = 4'h0;
    localparam logic [3:0] ALUSUB = 4'h1;
    localparam logic [3:0] ALUAND = 4'h2;
    localparam logic [3:0] ALUXOR = 4'h3;
    localparam logic [3:0] ALUMUL = 4'h4;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd2;
    localparam logic [2:0] SINS = 3'd3;
    localparam logic [2:0] SHLT = 3'd4;

    localparam logic [3:0] RESP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    typedef enum logic [1:0] {StIdle, StRun, StDone} mul_state_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == SADR) || (stat == SINS) || (stat == SHLT);
    endfunction

    function automatic logic cond_eval(input cc_t cc, input logic [3:0] ifun);
        logic lt;
        lt = cc.sf ^ cc.of;
        case (ifun)
            C_YES:   return 1'b1;
            C_LE:    return lt | cc.zf;
            C_L:     return lt;
            C_E:     return cc.zf;
            C_NE:    return ~cc.zf;
            C_GE:    return ~lt;
            C_G:     return ~lt & ~cc.zf;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_mc_if.sv
// E-register inputs, downstream status and e_* outputs of the Y86 execute stage.
interface execute_mc_if #(
    parameter int unsigned WIDTH = 64
);
    logic [2:0]       E_stat;
    logic [3:0]       E_icode;
    logic [3:0]       E_ifun;
    logic [WIDTH-1:0] E_valC;
    logic [WIDTH-1:0] E_valA;
    logic [WIDTH-1:0] E_valB;
    logic [3:0]       E_dstE;
    logic [3:0]       E_dstM;
    logic [2:0]       m_stat;
    logic [2:0]       W_stat;

    logic [2:0]       e_stat;
    logic [3:0]       e_icode;
    logic             e_Cnd;
    logic [WIDTH-1:0] e_valE;
    logic [WIDTH-1:0] e_valA;
    logic [3:0]       e_dstE;
    logic [3:0]       e_dstM;
    logic             e_busy;
    logic [2:0]       e_cc;

    modport master (
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
        output m_stat, W_stat,
        input  e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM, e_busy, e_cc
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
        input  m_stat, W_stat,
        output e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM, e_busy, e_cc
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative signed multiplier retiring STEP_BITS multiplier bits per cycle (IDLE/RUN/DONE).
// Only built when EXEC_MUL_EN is defined.
`ifdef EXEC_MUL_EN
module seq_multiplier
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned STEP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic             overflow
);
    localparam int unsigned N     = WIDTH / STEP_BITS;
    localparam int unsigned CNT_W = $clog2(N + 1);

    mul_state_e           state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 neg_q, neg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [2*WIDTH-1:0]   step_sum;
    logic [2*WIDTH-1:0]   product;

    // Magnitudes are unsigned, so the most negative operand still fits.
    assign a_abs = a[WIDTH-1] ? -a : a;
    assign b_abs = b[WIDTH-1] ? -b : b;

    always_comb begin
        step_sum = '0;
        for (int i = 0; i < int'(STEP_BITS); i++) begin
            if (mplier_q[i]) step_sum = step_sum + (mcand_q << i);
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_abs};
                    mplier_d = b_abs;
                    neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = CNT_W'(N);
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_d    = acc_q + step_sum;
                mcand_d  = mcand_q << STEP_BITS;
                mplier_d = mplier_q >> STEP_BITS;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy       = ((state_q == StIdle) && start) || (state_q == StRun);
    assign done       = (state_q == StDone);
    assign product    = neg_q ? -acc_q : acc_q;
    assign product_lo = product[WIDTH-1:0];
    assign overflow   = (product != {{WIDTH{product[WIDTH-1]}}, product[WIDTH-1:0]});

endmodule
`endif

// File: rtl/execute_mc.sv
// Y86 execute stage with registered condition codes and optional multi-cycle OPq multiply.
// Multiply (OPQ ifun 4) is built only when EXEC_MUL_EN is defined; otherwise it raises SINS.
module execute_mc
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned STEP_BITS = 1
) (
    input logic         clk,
    input logic         rst,
    execute_mc_if.slave ex
);
    localparam logic [WIDTH-1:0] POS8 = WIDTH'(8);
    localparam logic [WIDTH-1:0] NEG8 = ~WIDTH'(7);

    cc_t              cc_q, cc_d;
    logic             cc_load;
    logic [WIDTH-1:0] alu_a, alu_b, alu_r;
    logic             alu_of;
    logic [3:0]       alu_fn;
    logic             is_opq, mul_req, bad_fn, stage_ok, set_cc, cnd;
    logic [WIDTH-1:0] res_val;
    logic             res_of;
    logic             mul_busy, mul_done, mul_of;
    logic [WIDTH-1:0] mul_lo;

    assign is_opq   = (ex.E_icode == IOPQ);
    assign mul_req  = is_opq && (ex.E_ifun == ALUMUL);
    assign stage_ok = (ex.E_stat == SAOK);
`ifdef EXEC_MUL_EN
    assign bad_fn   = is_opq && (ex.E_ifun > ALUMUL);
`else
    assign bad_fn   = is_opq && (ex.E_ifun > ALUXOR);
`endif
    assign set_cc   = is_opq && stage_ok && !bad_fn && !is_exc(ex.m_stat) && !is_exc(ex.W_stat);

    always_comb begin
        alu_a = '0;
        case (ex.E_icode)
            IRRMOVQ, IOPQ:           alu_a = ex.E_valA;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = ex.E_valC;
            ICALL, IPUSHQ:           alu_a = NEG8;
            IRET, IPOPQ:             alu_a = POS8;
            default:                 alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (ex.E_icode)
            IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alu_b = ex.E_valB;
            default:                                            alu_b = '0;
        endcase
    end

    assign alu_fn = is_opq ? ex.E_ifun : ALUADD;

    always_comb begin
        alu_r  = '0;
        alu_of = 1'b0;
        case (alu_fn)
            ALUADD: begin
                alu_r  = alu_b + alu_a;
                alu_of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_a[WIDTH-1]);
            end
            ALUSUB: begin
                alu_r  = alu_b - alu_a;
                alu_of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_b[WIDTH-1]);
            end
            ALUAND:  alu_r = alu_b & alu_a;
            ALUXOR:  alu_r = alu_b ^ alu_a;
            default: alu_r = '0;
        endcase
    end

`ifdef EXEC_MUL_EN
    logic mul_start;

    // The multiplier ignores start outside IDLE, so the held E register cannot relaunch it.
    assign mul_start = mul_req && stage_ok;

    seq_multiplier #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS)
    ) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start      (mul_start),
        .a          (ex.E_valA),
        .b          (ex.E_valB),
        .busy       (mul_busy),
        .done       (mul_done),
        .product_lo (mul_lo),
        .overflow   (mul_of)
    );
`else
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_lo   = '0;
    assign mul_of   = 1'b0;
`endif

    always_comb begin
        res_val = alu_r;
        res_of  = alu_of;
        if (mul_done) begin
            res_val = mul_lo;
            res_of  = mul_of;
        end else if (mul_req || bad_fn) begin
            res_val = '0;
            res_of  = 1'b0;
        end
    end

    assign cc_load = set_cc && (mul_req ? mul_done : 1'b1);
    assign cc_d    = '{zf: (res_val == '0), sf: res_val[WIDTH-1], of: res_of};

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
        end else if (cc_load) begin
            cc_q <= cc_d;
        end
    end

    // Condition uses the CC from before this instruction.
    assign cnd = ((ex.E_icode == IRRMOVQ) || (ex.E_icode == IJXX)) && cond_eval(cc_q, ex.E_ifun);

    always_comb begin
        ex.e_stat  = (bad_fn && stage_ok) ? SINS : ex.E_stat;
        ex.e_icode = ex.E_icode;
        ex.e_Cnd   = cnd;
        ex.e_valE  = res_val;
        ex.e_valA  = ex.E_valA;
        ex.e_dstE  = ((ex.E_icode == IRRMOVQ) && !cnd) ? RNONE : ex.E_dstE;
        ex.e_dstM  = ex.E_dstM;
        ex.e_busy  = mul_busy;
        ex.e_cc    = cc_q;
        if (mul_busy) begin
            ex.e_stat  = SAOK;
            ex.e_icode = INOP;
            ex.e_Cnd   = 1'b0;
            ex.e_valE  = '0;
            ex.e_dstE  = RNONE;
            ex.e_dstM  = RNONE;
        end
    end

endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc: a 64-bit instance for ALU/CC/condition checks and a
// 16-bit, 4-bit-step instance for the multiply path (or its SINS trap when EXEC_MUL_EN is off).
module tb_execute_mc;
    import y86_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n;

    always #5 clk = ~clk;

    execute_mc_if #(.WIDTH(64)) if64 ();
    execute_mc_if #(.WIDTH(16)) if16 ();

    execute_mc #(.WIDTH(64), .STEP_BITS(1)) u64 (
        .clk (clk),
        .rst (rst),
        .ex  (if64)
    );

    execute_mc #(.WIDTH(16), .STEP_BITS(4)) u16 (
        .clk (clk),
        .rst (rst),
        .ex  (if16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go64(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic [2:0] mst);
        @(posedge clk);
        #1;
        if64.E_stat = SAOK; if64.E_icode = icode; if64.E_ifun = ifun;
        if64.E_valA = a; if64.E_valB = b; if64.E_valC = c;
        if64.E_dstE = 4'h3; if64.E_dstM = RNONE; if64.m_stat = mst; if64.W_stat = SAOK;
        #2;
    endtask

    task automatic go16(input logic [3:0] icode, input logic [3:0] ifun, input logic [15:0] a,
                        input logic [15:0] b);
        @(posedge clk);
        #1;
        if16.E_stat = SAOK; if16.E_icode = icode; if16.E_ifun = ifun;
        if16.E_valA = a; if16.E_valB = b; if16.E_valC = '0;
        if16.E_dstE = 4'h3; if16.E_dstM = RNONE; if16.m_stat = SAOK; if16.W_stat = SAOK;
        #2;
    endtask

    initial begin
        if64.E_stat = SAOK; if64.E_icode = INOP; if64.E_ifun = '0; if64.E_valA = '0;
        if64.E_valB = '0; if64.E_valC = '0; if64.E_dstE = RNONE; if64.E_dstM = RNONE;
        if64.m_stat = SAOK; if64.W_stat = SAOK;
        if16.E_stat = SAOK; if16.E_icode = INOP; if16.E_ifun = '0; if16.E_valA = '0;
        if16.E_valB = '0; if16.E_valC = '0; if16.E_dstE = RNONE; if16.E_dstM = RNONE;
        if16.m_stat = SAOK; if16.W_stat = SAOK;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("reset_cc64", if64.e_cc, 3'b100);
        chk("reset_busy16", if16.e_busy, 1'b0);

        go64(IJXX, C_E, 0, 0, 0, SAOK);
        chk("je_after_reset", if64.e_Cnd, 1'b1);
        chk("je_cc", if64.e_cc, 3'b100);

        go64(IOPQ, ALUADD, 64'd1, 64'd1, 0, SAOK);
        chk("add_1_1", if64.e_valE, 64'd2);
        go64(IOPQ, ALUSUB, 64'd5, 64'd5, 0, SAOK);
        chk("cc_after_add", if64.e_cc, 3'b000);
        chk("sub_5_5", if64.e_valE, 64'd0);
        chk("sub_stat", if64.e_stat, SAOK);
        go64(IOPQ, ALUSUB, 64'd1, 64'd0, 0, SADR);
        chk("cc_after_sub", if64.e_cc, 3'b100);
        chk("sub_wrap", if64.e_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        go64(IOPQ, ALUADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, SAOK);
        chk("cc_gated_by_m_sadr", if64.e_cc, 3'b100);
        chk("add_ovf", if64.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);

        // SF=1, OF=1: signed result is "greater or equal", not "less or equal".
        go64(IRRMOVQ, C_GE, 64'h1234, 0, 0, SAOK);
        chk("cc_after_ovf", if64.e_cc, 3'b011);
        chk("cmovge_cnd", if64.e_Cnd, 1'b1);
        chk("cmovge_dst", if64.e_dstE, 4'h3);
        chk("cmovge_val", if64.e_valE, 64'h1234);
        go64(IRRMOVQ, C_LE, 64'h1234, 0, 0, SAOK);
        chk("cmovle_cnd", if64.e_Cnd, 1'b0);
        chk("cmovle_dst", if64.e_dstE, RNONE);
        go64(IJXX, 4'h7, 0, 0, 0, SAOK);
        chk("jxx_bad_ifun", if64.e_Cnd, 1'b0);

        go64(ICALL, 4'h0, 0, 64'h100, 0, SAOK);
        chk("call_sp", if64.e_valE, 64'hF8);
        go64(IPOPQ, 4'h0, 0, 64'h100, 0, SAOK);
        chk("pop_sp", if64.e_valE, 64'h108);
        go64(IIRMOVQ, 4'h0, 64'h55, 64'h100, 64'hDEAD_BEEF, SAOK);
        chk("irmovq", if64.e_valE, 64'hDEAD_BEEF);
        go64(IOPQ, ALUXOR, 64'hF0F0, 64'hFF00, 0, SAOK);
        chk("xor", if64.e_valE, 64'h0FF0);
        go64(IOPQ, 4'h7, 64'd3, 64'd4, 0, SAOK);
        chk("xor_cc", if64.e_cc, 3'b000);
        chk("opq_bad_stat", if64.e_stat, SINS);
        chk("opq_bad_val", if64.e_valE, 64'd0);
        go64(INOP, 4'h0, 0, 0, 0, SAOK);
        chk("opq_bad_no_cc", if64.e_cc, 3'b000);

`ifdef EXEC_MUL_EN
        go16(IOPQ, ALUMUL, 16'hFFFD, 16'd7);
        chk("mul_launch_busy", if16.e_busy, 1'b1);
        chk("mul_bubble_icode", if16.e_icode, INOP);
        chk("mul_bubble_dst", if16.e_dstE, RNONE);
        n = 0;
        while (if16.e_busy === 1'b1 && n < 20) begin
            n++;
            @(posedge clk);
            #2;
        end
        chk("mul_busy_cycles", 64'(n), 64'd5);
        chk("mul_val", if16.e_valE, 16'hFFEB);
        chk("mul_done_icode", if16.e_icode, IOPQ);
        go16(INOP, 4'h0, 0, 0);
        chk("mul_cc", if16.e_cc, 3'b010);

        go16(IOPQ, ALUMUL, 16'h0100, 16'h0100);
        n = 0;
        while (if16.e_busy === 1'b1 && n < 20) begin
            n++;
            @(posedge clk);
            #2;
        end
        chk("mul2_busy_cycles", 64'(n), 64'd5);
        chk("mul2_val", if16.e_valE, 16'h0000);
        go16(INOP, 4'h0, 0, 0);
        chk("mul2_cc", if16.e_cc, 3'b101);

        go16(IOPQ, ALUMUL, 16'd3, 16'd3);
        @(posedge clk);
        #1;
        chk("mid_run_busy", if16.e_busy, 1'b1);
        rst = 1'b1;
        if16.E_icode = INOP;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", if16.e_busy, 1'b0);
        chk("abort_cc", if16.e_cc, 3'b100);
        go16(INOP, 4'h0, 0, 0);
        chk("abort_idle", if16.e_busy, 1'b0);
`else
        go16(IOPQ, ALUMUL, 16'd2, 16'd3);
        chk("mul_off_stat", if16.e_stat, SINS);
        chk("mul_off_busy", if16.e_busy, 1'b0);
        chk("mul_off_val", if16.e_valE, 16'h0000);
        go16(INOP, 4'h0, 0, 0);
        chk("mul_off_cc", if16.e_cc, 3'b100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
